seg_scan_capture: RTL

Observes the multiplexed seven-segment drive (`anode_active`, `segments`) produced by the display multiplexer and reconstructs the four displayed digits as BCD codes. It runs in the `clk_200` scan domain and sits beside the display path as a read-back and self-check monitor, feeding debug LEDs and on-board checks. It also flags illegal drive patterns and a stalled scan.

---
 rtl/seg_pkg.sv | 47 ++++
 rtl/seg7_decode.sv | 31 +++
 rtl/seg_scan_capture.sv | 131 +++++++++++++
 3 files changed

// File: rtl/seg_pkg.sv
// Shared seven-segment encoding for the display multiplexer and the scan capture monitor.
// Patterns are active-low {g,f,e,d,c,b,a}.
package seg_pkg;

  localparam int NUM_ANODES = 4;

  localparam logic [3:0] CODE_BLANK   = 4'hA;
  localparam logic [3:0] CODE_INVALID = 4'hE;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    ANODE_IDLE  = 2'd0,
    ANODE_VALID = 2'd1,
    ANODE_MULTI = 2'd2
  } anode_class_t;

  // Encoder used by the multiplexer; any non-digit code drives a blank digit.
  function automatic logic [6:0] seg_encode(input logic [3:0] code);
    logic [6:0] p;
    case (code)
      4'd0:    p = SEG_0;
      4'd1:    p = SEG_1;
      4'd2:    p = SEG_2;
      4'd3:    p = SEG_3;
      4'd4:    p = SEG_4;
      4'd5:    p = SEG_5;
      4'd6:    p = SEG_6;
      4'd7:    p = SEG_7;
      4'd8:    p = SEG_8;
      4'd9:    p = SEG_9;
      default: p = SEG_BLANK;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational seven-segment pattern to BCD decode; unknown patterns map to CODE_INVALID.
module seg7_decode
  import seg_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] code,
  output logic       invalid
);

  always_comb begin
    invalid = 1'b0;
    case (seg)
      SEG_0:     code = 4'd0;
      SEG_1:     code = 4'd1;
      SEG_2:     code = 4'd2;
      SEG_3:     code = 4'd3;
      SEG_4:     code = 4'd4;
      SEG_5:     code = 4'd5;
      SEG_6:     code = 4'd6;
      SEG_7:     code = 4'd7;
      SEG_8:     code = 4'd8;
      SEG_9:     code = 4'd9;
      SEG_BLANK: code = CODE_BLANK;
      default: begin
        code    = CODE_INVALID;
        invalid = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/seg_scan_capture.sv
// Read-back monitor for the multiplexed seven-segment drive: rebuilds the four displayed
// digits, publishes complete frames, and flags illegal patterns, anode overlap and scan stall.
module seg_scan_capture
  import seg_pkg::*;
#(
  parameter int STALL_CYCLES = 16
) (
  input  logic                  clk_200,
  input  logic                  rst,
  input  logic                  clear,
  input  logic [NUM_ANODES-1:0] anode_active,
  input  logic [7:0]            segments,
  output logic [15:0]           digits,
  output logic [3:0]            dps,
  output logic                  frame_valid,
  output logic                  frame_changed,
  output logic                  invalid_seen,
  output logic                  anode_err,
  output logic                  stall
);

  localparam int CW = $clog2(STALL_CYCLES + 1);
  localparam logic [CW-1:0] STALL_MAX = CW'(STALL_CYCLES);

  logic [3:0]            dec_code;
  logic                  dec_invalid;
  logic [2:0]            zero_cnt;
  anode_class_t          anode_class;
  logic [NUM_ANODES-1:0] slot_sel;
  logic                  entry;
  logic                  publish;
  logic [NUM_ANODES-1:0] seen;
  logic [NUM_ANODES-1:0] seen_next;
  logic [NUM_ANODES-1:0] prev_anode;
  logic [15:0]           work_digits;
  logic [3:0]            work_dps;
  logic [15:0]           merged_digits;
  logic [3:0]            merged_dps;
  logic [CW-1:0]         stall_cnt;

  seg7_decode u_decode (
    .seg     (segments[6:0]),
    .code    (dec_code),
    .invalid (dec_invalid)
  );

  always_comb begin
    zero_cnt = 3'd0;
    for (int i = 0; i < NUM_ANODES; i++) begin
      zero_cnt = zero_cnt + {2'b00, ~anode_active[i]};
    end
    if (zero_cnt == 3'd0)      anode_class = ANODE_IDLE;
    else if (zero_cnt == 3'd1) anode_class = ANODE_VALID;
    else                       anode_class = ANODE_MULTI;
  end

  // A valid anode captures every cycle; only a change of anode counts as an entry.
  always_comb begin
    slot_sel  = (anode_class == ANODE_VALID) ? ~anode_active : '0;
    entry     = (anode_class == ANODE_VALID) && (anode_active != prev_anode);
    seen_next = seen | slot_sel;
    publish   = entry && (seen_next == 4'hF);
  end

  always_comb begin
    merged_digits = work_digits;
    merged_dps    = work_dps;
    for (int i = 0; i < NUM_ANODES; i++) begin
      if (slot_sel[i]) begin
        merged_digits[i*4 +: 4] = dec_code;
        merged_dps[i]           = ~segments[7];
      end
    end
  end

  always_ff @(posedge clk_200 or posedge rst) begin
    if (rst) begin
      digits        <= {4{CODE_BLANK}};
      dps           <= 4'h0;
      frame_valid   <= 1'b0;
      frame_changed <= 1'b0;
      seen          <= '0;
      prev_anode    <= 4'hF;
      work_digits   <= {4{CODE_BLANK}};
      work_dps      <= 4'h0;
    end else begin
      frame_valid   <= 1'b0;
      frame_changed <= 1'b0;
      work_digits   <= merged_digits;
      work_dps      <= merged_dps;
      if (entry) begin
        prev_anode <= anode_active;
        if (publish) begin
          digits        <= merged_digits;
          dps           <= merged_dps;
          frame_valid   <= 1'b1;
          frame_changed <= (merged_digits != digits) || (merged_dps != dps);
          seen          <= '0;
        end else begin
          seen <= seen_next;
        end
      end
    end
  end

  // Sticky flags: a new error in the same cycle as clear keeps the flag set.
  always_ff @(posedge clk_200 or posedge rst) begin
    if (rst) begin
      invalid_seen <= 1'b0;
      anode_err    <= 1'b0;
    end else begin
      if ((anode_class == ANODE_VALID) && dec_invalid) invalid_seen <= 1'b1;
      else if (clear)                                   invalid_seen <= 1'b0;
      if (anode_class == ANODE_MULTI) anode_err <= 1'b1;
      else if (clear)                 anode_err <= 1'b0;
    end
  end

  always_ff @(posedge clk_200 or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (entry || clear) begin
      stall_cnt <= '0;
    end else if (stall_cnt != STALL_MAX) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

  assign stall = (stall_cnt == STALL_MAX);

endmodule
